add_serial: RTL

Parametrised multi-cycle adder/subtractor that processes `DIGIT` bits per clock, so a `WIDTH`-bit result takes `WIDTH/DIGIT` cycles. It replaces the single-cycle combinational 8-bit adder where area matters more than latency. It keeps that adder's `A`/`B`/`C0`/`E` operand semantics and adds a start/busy/done handshake, a subtract mode and an overflow flag. It sits between operand registers and the result bus of the datapath.

---
 rtl/add_pkg.sv | 19 +
 rtl/add_digit.sv | 24 ++
 rtl/add_serial.sv | 124 ++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: state encoding,
// mode constants and the parameter legality check.
package add_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // WIDTH must split into a whole number of DIGIT-bit slices.
    function automatic bit params_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/add_digit.sv
// Combinational DIGIT-bit adder slice; also reports the carry into its MSB
// so the top level can derive signed overflow on the last slice.
module add_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
        sum   = full[DIGIT-1:0];
        co    = full[DIGIT];
        // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
        c_msb = sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
    end

endmodule

// File: rtl/add_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, WIDTH/DIGIT cycles per
// result, with start/busy/done handshake, enable freeze and overflow flag.
module add_serial
    import add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic             start,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OV,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("add_serial: WIDTH must be a multiple of DIGIT and DIGIT in 1..WIDTH");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, co_q, co_d, ov_q, ov_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_co, dig_cmsb;

    add_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .sum   (dig_sum),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (E) begin
                    state_d = ST_IDLE;
                    if (start) begin
                        // Subtraction is A + ~B + ~C0, so a borrow-in of 1 drops the +1.
                        state_d = ST_RUN;
                        a_d     = A;
                        b_d     = (MODE == MODE_SUB) ? ~B  : B;
                        carry_d = (MODE == MODE_SUB) ? ~C0 : C0;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                if (E) begin
                    a_d     = a_q >> DIGIT;
                    b_d     = b_q >> DIGIT;
                    carry_d = dig_co;
                    cnt_d   = cnt_q + CW'(1);
                    res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = ST_DONE;
                        s_d     = res_d;
                        co_d    = dig_co;
                        ov_d    = dig_cmsb ^ dig_co;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign S    = s_q;
    assign CO   = co_q;
    assign OV   = ov_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule
